// File: rtl/lpif_gearbox_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_gearbox_pkg : slice field widths, width helpers and shared types. Rev 1.0
// ----------------------------------------------------------------------------
package lpif_gearbox_pkg;
  localparam int STATE_W  = 4;
  localparam int PROTID_W = 2;

  typedef enum logic [0:0] {
    TX_IDLE = 1'b0,
    TX_SEND = 1'b1
  } tx_state_e;

  // Narrow per-slice qualifiers; data and crc widths are set per instance.
  typedef struct packed {
    logic                valid;
    logic                crc_valid;
    logic                dvalid;
    logic [PROTID_W-1:0] protid;
    logic [STATE_W-1:0]  state;
  } slice_ctl_t;

  function automatic int slice_w(input int data_w, input int crc_w);
    return data_w + crc_w + STATE_W + PROTID_W + 3;
  endfunction

  function automatic int link_w(input int link_slices, input int sw);
    return link_slices * sw + 1;
  endfunction
endpackage
`default_nettype wire

// File: rtl/lpif_txrx_asym_gearbox_if.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_txrx_asym_gearbox_if : LPIF user beats and link words around the gearbox. Rev 1.0
// ----------------------------------------------------------------------------
interface lpif_txrx_asym_gearbox_if
  import lpif_gearbox_pkg::*;
#(
  parameter int USER_SLICES = 2,
  parameter int LINK_SLICES = 1,
  parameter int DATA_W      = 256,
  parameter int CRC_W       = 8
);
  localparam int c_SW = slice_w(DATA_W, CRC_W);
  localparam int c_LW = link_w(LINK_SLICES, c_SW);

  logic [STATE_W*USER_SLICES-1:0]  dstrm_state;
  logic [PROTID_W*USER_SLICES-1:0] dstrm_protid;
  logic [DATA_W*USER_SLICES-1:0]   dstrm_data;
  logic [USER_SLICES-1:0]          dstrm_dvalid;
  logic [CRC_W*USER_SLICES-1:0]    dstrm_crc;
  logic [USER_SLICES-1:0]          dstrm_crc_valid;
  logic [USER_SLICES-1:0]          dstrm_valid;
  logic                            user_downstream_vld;
  logic                            user_downstream_ready;
  logic [c_LW-1:0]                 txfifo_downstream_data;
  logic                            txfifo_downstream_vld;
  logic                            txfifo_downstream_ready;
  logic [c_LW-1:0]                 rxfifo_upstream_data;
  logic                            rxfifo_upstream_vld;
  logic [STATE_W*USER_SLICES-1:0]  ustrm_state;
  logic [PROTID_W*USER_SLICES-1:0] ustrm_protid;
  logic [DATA_W*USER_SLICES-1:0]   ustrm_data;
  logic [USER_SLICES-1:0]          ustrm_dvalid;
  logic [CRC_W*USER_SLICES-1:0]    ustrm_crc;
  logic [USER_SLICES-1:0]          ustrm_crc_valid;
  logic [USER_SLICES-1:0]          ustrm_valid;
  logic                            user_upstream_vld;
  logic                            rx_align_err;

  modport slave (
    input  dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
           dstrm_crc_valid, dstrm_valid, user_downstream_vld, txfifo_downstream_ready,
           rxfifo_upstream_data, rxfifo_upstream_vld,
    output user_downstream_ready, txfifo_downstream_data, txfifo_downstream_vld,
           ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
           ustrm_crc_valid, ustrm_valid, user_upstream_vld, rx_align_err
  );

  modport master (
    output dstrm_state, dstrm_protid, dstrm_data, dstrm_dvalid, dstrm_crc,
           dstrm_crc_valid, dstrm_valid, user_downstream_vld, txfifo_downstream_ready,
           rxfifo_upstream_data, rxfifo_upstream_vld,
    input  user_downstream_ready, txfifo_downstream_data, txfifo_downstream_vld,
           ustrm_state, ustrm_protid, ustrm_data, ustrm_dvalid, ustrm_crc,
           ustrm_crc_valid, ustrm_valid, user_upstream_vld, rx_align_err
  );
endinterface
`default_nettype wire

// File: rtl/lpif_slice_pack.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_slice_pack : packs one TX slice into link bits and unpacks one RX slice. Rev 1.0
// ----------------------------------------------------------------------------
module lpif_slice_pack
  import lpif_gearbox_pkg::*;
#(
  parameter int DATA_W = 256,
  parameter int CRC_W  = 8,
  localparam int c_SW  = slice_w(DATA_W, CRC_W)
) (
  input  wire slice_ctl_t        i_ctl,
  input  wire [DATA_W-1:0]       i_data,
  input  wire [CRC_W-1:0]        i_crc,
  output logic [c_SW-1:0]        o_slice,
  input  wire [c_SW-1:0]         i_slice,
  output slice_ctl_t             o_ctl,
  output logic [DATA_W-1:0]      o_data,
  output logic [CRC_W-1:0]       o_crc
);
  // LSB first: state, protid, data, dvalid, crc, crc_valid, valid.
  assign o_slice = {i_ctl.valid, i_ctl.crc_valid, i_crc, i_ctl.dvalid, i_data,
                    i_ctl.protid, i_ctl.state};

  assign {o_ctl.valid, o_ctl.crc_valid, o_crc, o_ctl.dvalid, o_data,
          o_ctl.protid, o_ctl.state} = i_slice;
endmodule
`default_nettype wire

// File: rtl/lpif_txrx_asym_gearbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// lpif_txrx_asym_gearbox : serialises USER_SLICES beats into LINK_SLICES link words and back. Rev 1.0
// ----------------------------------------------------------------------------
module lpif_txrx_asym_gearbox
  import lpif_gearbox_pkg::*;
#(
  parameter int USER_SLICES = 2,
  parameter int LINK_SLICES = 1,
  parameter int DATA_W      = 256,
  parameter int CRC_W       = 8
) (
  input wire                      clk_wr,
  input wire                      rst_wr_n,
  lpif_txrx_asym_gearbox_if.slave bus
);
  localparam int c_RATIO = USER_SLICES / LINK_SLICES;
  localparam int c_SW    = slice_w(DATA_W, CRC_W);
  localparam int c_CW    = LINK_SLICES * c_SW;
  localparam int c_BW    = USER_SLICES * c_SW;
  localparam int c_KW    = (c_RATIO > 1) ? $clog2(c_RATIO) : 1;
  localparam logic [c_KW-1:0] c_K_LAST = c_KW'(c_RATIO - 1);

  logic [c_BW-1:0] w_tx_beat;
  logic [c_BW-1:0] r_tx_beat;
  logic [c_BW-1:0] r_rx_part;
  logic [c_BW-1:0] w_rx_merge;
  logic [c_BW-1:0] r_rx_beat;

  for (genvar i = 0; i < USER_SLICES; i++) begin : g_slice
    slice_ctl_t w_tx_ctl;
    slice_ctl_t w_rx_ctl;

    assign w_tx_ctl.state     = bus.dstrm_state[i*STATE_W +: STATE_W];
    assign w_tx_ctl.protid    = bus.dstrm_protid[i*PROTID_W +: PROTID_W];
    assign w_tx_ctl.dvalid    = bus.dstrm_dvalid[i];
    assign w_tx_ctl.crc_valid = bus.dstrm_crc_valid[i];
    assign w_tx_ctl.valid     = bus.dstrm_valid[i];

    lpif_slice_pack #(.DATA_W(DATA_W), .CRC_W(CRC_W)) u_pack (
      .i_ctl   (w_tx_ctl),
      .i_data  (bus.dstrm_data[i*DATA_W +: DATA_W]),
      .i_crc   (bus.dstrm_crc[i*CRC_W +: CRC_W]),
      .o_slice (w_tx_beat[i*c_SW +: c_SW]),
      .i_slice (r_rx_beat[i*c_SW +: c_SW]),
      .o_ctl   (w_rx_ctl),
      .o_data  (bus.ustrm_data[i*DATA_W +: DATA_W]),
      .o_crc   (bus.ustrm_crc[i*CRC_W +: CRC_W])
    );

    assign bus.ustrm_state[i*STATE_W +: STATE_W]    = w_rx_ctl.state;
    assign bus.ustrm_protid[i*PROTID_W +: PROTID_W] = w_rx_ctl.protid;
    assign bus.ustrm_dvalid[i]                      = w_rx_ctl.dvalid;
    assign bus.ustrm_crc_valid[i]                   = w_rx_ctl.crc_valid;
    assign bus.ustrm_valid[i]                       = w_rx_ctl.valid;
  end

  // ---------------- TX ----------------
  tx_state_e       r_tx_state;
  tx_state_e       w_tx_state_nxt;
  logic [c_KW-1:0] r_tx_k;
  logic            w_tx_ready;
  logic            w_tx_last;
  logic            w_tx_adv;
  logic            w_tx_accept;

  assign w_tx_last   = (r_tx_k == c_K_LAST);
  assign w_tx_adv    = (r_tx_state == TX_SEND) && bus.txfifo_downstream_ready;
  assign w_tx_accept = bus.user_downstream_vld && w_tx_ready;

  always_comb begin
    w_tx_state_nxt = r_tx_state;
    w_tx_ready     = 1'b0;
    case (r_tx_state)
      TX_IDLE: begin
        w_tx_ready = rst_wr_n;
        if (w_tx_accept) w_tx_state_nxt = TX_SEND;
      end
      TX_SEND: begin
        // Taking the next beat on the last chunk's handshake avoids a bubble.
        w_tx_ready = rst_wr_n && w_tx_last && bus.txfifo_downstream_ready;
        if (w_tx_adv && w_tx_last && !bus.user_downstream_vld) w_tx_state_nxt = TX_IDLE;
      end
      default: w_tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_tx_state <= TX_IDLE;
      r_tx_beat  <= '0;
      r_tx_k     <= '0;
    end else begin
      r_tx_state <= w_tx_state_nxt;
      if (w_tx_accept) begin
        r_tx_beat <= w_tx_beat;
        r_tx_k    <= '0;
      end else if (w_tx_adv) begin
        r_tx_k <= w_tx_last ? '0 : r_tx_k + 1'b1;
      end
    end
  end

  assign bus.user_downstream_ready  = w_tx_ready;
  assign bus.txfifo_downstream_vld  = (r_tx_state == TX_SEND);
  assign bus.txfifo_downstream_data = (r_tx_state == TX_SEND) ?
                                      {(r_tx_k == '0), r_tx_beat[r_tx_k*c_CW +: c_CW]} : '0;

  // ---------------- RX ----------------
  logic [c_KW-1:0] r_rx_k;
  logic [c_KW-1:0] w_rx_idx;
  logic [c_CW-1:0] w_rx_chunk;
  logic            w_rx_marker;
  logic            w_rx_take;
  logic            w_rx_err;
  logic            w_rx_last;
  logic            r_rx_vld;
  logic            r_rx_err;

  assign w_rx_marker = bus.rxfifo_upstream_data[c_CW];
  assign w_rx_chunk  = bus.rxfifo_upstream_data[c_CW-1:0];
  assign w_rx_idx    = w_rx_marker ? '0 : r_rx_k;
  assign w_rx_last   = (w_rx_idx == c_K_LAST);
  assign w_rx_take   = bus.rxfifo_upstream_vld && (w_rx_marker || (r_rx_k != '0));
  // A marker mid-beat restarts alignment; a non-marker with nothing pending is dropped.
  assign w_rx_err    = bus.rxfifo_upstream_vld && (w_rx_marker == (r_rx_k != '0));

  always_comb begin
    w_rx_merge = r_rx_part;
    w_rx_merge[w_rx_idx*c_CW +: c_CW] = w_rx_chunk;
  end

  always_ff @(posedge clk_wr or negedge rst_wr_n) begin
    if (!rst_wr_n) begin
      r_rx_k    <= '0;
      r_rx_part <= '0;
      r_rx_beat <= '0;
      r_rx_vld  <= 1'b0;
      r_rx_err  <= 1'b0;
    end else begin
      r_rx_vld <= 1'b0;
      r_rx_err <= w_rx_err;
      if (w_rx_take) begin
        r_rx_part <= w_rx_merge;
        r_rx_k    <= w_rx_last ? '0 : w_rx_idx + 1'b1;
        if (w_rx_last) begin
          r_rx_beat <= w_rx_merge;
          r_rx_vld  <= 1'b1;
        end
      end
    end
  end

  assign bus.user_upstream_vld = r_rx_vld;
  assign bus.rx_align_err      = r_rx_err;
endmodule
`default_nettype wire

// File: tb/tb_lpif_txrx_asym_gearbox.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_lpif_txrx_asym_gearbox : directed bench for the x2 default gearbox and a 4:2 variant. Rev 1.0
// ----------------------------------------------------------------------------
module tb_lpif_txrx_asym_gearbox;
  localparam int SW_A = 273;
  localparam int LW_A = 274;
  localparam int SW_B = 33;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  lpif_txrx_asym_gearbox_if #(.USER_SLICES(2), .LINK_SLICES(1), .DATA_W(256), .CRC_W(8)) bus_a ();
  lpif_txrx_asym_gearbox_if #(.USER_SLICES(4), .LINK_SLICES(2), .DATA_W(16), .CRC_W(8)) bus_b ();

  lpif_txrx_asym_gearbox #(.USER_SLICES(2), .LINK_SLICES(1), .DATA_W(256), .CRC_W(8)) u_dut_a (
    .clk_wr(clk), .rst_wr_n(rst_n), .bus(bus_a.slave));
  lpif_txrx_asym_gearbox #(.USER_SLICES(4), .LINK_SLICES(2), .DATA_W(16), .CRC_W(8)) u_dut_b (
    .clk_wr(clk), .rst_wr_n(rst_n), .bus(bus_b.slave));

  logic            loop_a;
  logic            man_vld;
  logic [LW_A-1:0] man_data;

  always_comb begin
    if (loop_a) begin
      bus_a.rxfifo_upstream_vld  = bus_a.txfifo_downstream_vld & bus_a.txfifo_downstream_ready;
      bus_a.rxfifo_upstream_data = bus_a.txfifo_downstream_data;
    end else begin
      bus_a.rxfifo_upstream_vld  = man_vld;
      bus_a.rxfifo_upstream_data = man_data;
    end
  end

  always_comb begin
    bus_b.rxfifo_upstream_vld  = bus_b.txfifo_downstream_vld & bus_b.txfifo_downstream_ready;
    bus_b.rxfifo_upstream_data = bus_b.txfifo_downstream_data;
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  function automatic logic [SW_A-1:0] mk_a(input logic [3:0] st, input logic [1:0] pr,
      input logic [255:0] d, input logic dv, input logic [7:0] c, input logic cv, input logic v);
    return {v, cv, c, dv, d, pr, st};
  endfunction

  function automatic logic [SW_B-1:0] mk_b(input logic [3:0] st, input logic [1:0] pr,
      input logic [15:0] d, input logic dv, input logic [7:0] c, input logic cv, input logic v);
    return {v, cv, c, dv, d, pr, st};
  endfunction

  function automatic logic [33:0] rest_a();
    return {bus_a.ustrm_state, bus_a.ustrm_protid, bus_a.ustrm_dvalid, bus_a.ustrm_crc,
            bus_a.ustrm_crc_valid, bus_a.ustrm_valid};
  endfunction

  task automatic drive_a(input logic [7:0] st, input logic [3:0] pr, input logic [511:0] d,
      input logic [1:0] dv, input logic [15:0] c, input logic [1:0] cv, input logic [1:0] v);
    bus_a.dstrm_state     = st;
    bus_a.dstrm_protid    = pr;
    bus_a.dstrm_data      = d;
    bus_a.dstrm_dvalid    = dv;
    bus_a.dstrm_crc       = c;
    bus_a.dstrm_crc_valid = cv;
    bus_a.dstrm_valid     = v;
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: bench did not finish");
    $fatal(1);
  end

  logic [255:0] d5, da, d1, d2;
  logic [511:0] q_data[$];
  logic [33:0]  q_rest[$];
  int           q_cyc[$];

  initial begin
    int cyc, got, sent, last_acc, hits;
    logic acc, done;
    logic [511:0] rd;
    logic [LW_A-1:0] w1, w2, w3;
    logic [15:0] bst; logic [7:0] bpr; logic [63:0] bdt; logic [3:0] bdv, bcv, bv; logic [31:0] bcrc;

    d5 = {64{4'h5}};
    da = {64{4'hA}};
    d1 = {8{32'hDEADBEEF}};
    d2 = {8{32'h01234567}};
    loop_a  = 1'b1;
    man_vld = 1'b0;
    man_data = '0;
    drive_a(8'h0, 4'h0, '0, 2'b0, 16'h0, 2'b0, 2'b0);
    bus_a.user_downstream_vld     = 1'b0;
    bus_a.txfifo_downstream_ready = 1'b1;
    bus_b.dstrm_state = '0; bus_b.dstrm_protid = '0; bus_b.dstrm_data = '0;
    bus_b.dstrm_dvalid = '0; bus_b.dstrm_crc = '0; bus_b.dstrm_crc_valid = '0;
    bus_b.dstrm_valid = '0;
    bus_b.user_downstream_vld     = 1'b0;
    bus_b.txfifo_downstream_ready = 1'b1;

    // Reset values
    #1 rst_n = 1'b0;
    step(); step();
    check("rst_ready", bus_a.user_downstream_ready, 1'b0);
    check("rst_txvld", bus_a.txfifo_downstream_vld, 1'b0);
    check("rst_txdata", bus_a.txfifo_downstream_data, '0);
    check("rst_upvld", bus_a.user_upstream_vld, 1'b0);
    check("rst_udata", bus_a.ustrm_data, '0);
    check("rst_err", bus_a.rx_align_err, 1'b0);
    rst_n = 1'b1;
    #1 check("ready_after_rst", bus_a.user_downstream_ready, 1'b1);
    step();

    // Default beat, link never stalled
    drive_a(8'h21, 4'h6, {da, d5}, 2'b11, 16'hC33C, 2'b11, 2'b11);
    bus_a.user_downstream_vld = 1'b1;
    step();
    bus_a.user_downstream_vld = 1'b0;
    #1;
    check("b1_c0_vld", bus_a.txfifo_downstream_vld, 1'b1);
    check("b1_c0_word", bus_a.txfifo_downstream_data, {1'b1, mk_a(4'h1, 2'h2, d5, 1'b1, 8'h3C, 1'b1, 1'b1)});
    check("b1_c0_ready", bus_a.user_downstream_ready, 1'b0);
    step();
    check("b1_c1_word", bus_a.txfifo_downstream_data, {1'b0, mk_a(4'h2, 2'h1, da, 1'b1, 8'hC3, 1'b1, 1'b1)});
    check("b1_c1_ready", bus_a.user_downstream_ready, 1'b1);
    check("b1_c1_upvld", bus_a.user_upstream_vld, 1'b0);
    step();
    check("b1_up_vld", bus_a.user_upstream_vld, 1'b1);
    check("b1_up_data", bus_a.ustrm_data, {da, d5});
    check("b1_up_rest", rest_a(), {8'h21, 4'h6, 2'b11, 16'hC33C, 2'b11, 2'b11});
    check("b1_idle_txvld", bus_a.txfifo_downstream_vld, 1'b0);
    step();
    check("b1_pulse_end", bus_a.user_upstream_vld, 1'b0);
    check("b1_hold", bus_a.ustrm_data, {da, d5});

    // Link stalled for 3 cycles during chunk 1
    drive_a(8'h93, 4'h9, {d1, d2}, 2'b01, 16'h5AA5, 2'b10, 2'b11);
    bus_a.user_downstream_vld = 1'b1;
    step();
    bus_a.user_downstream_vld = 1'b0;
    check("st_c0_word", bus_a.txfifo_downstream_data, {1'b1, mk_a(4'h3, 2'h1, d2, 1'b1, 8'hA5, 1'b0, 1'b1)});
    step();
    bus_a.txfifo_downstream_ready = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("st_hold_word", bus_a.txfifo_downstream_data, {1'b0, mk_a(4'h9, 2'h2, d1, 1'b0, 8'h5A, 1'b1, 1'b1)});
      check("st_hold_ready", bus_a.user_downstream_ready, 1'b0);
      check("st_hold_upvld", bus_a.user_upstream_vld, 1'b0);
    end
    bus_a.txfifo_downstream_ready = 1'b1;
    #1 check("st_release_ready", bus_a.user_downstream_ready, 1'b1);
    step();
    check("st_up_vld", bus_a.user_upstream_vld, 1'b1);
    check("st_up_data", bus_a.ustrm_data, {d1, d2});
    check("st_up_rest", rest_a(), {8'h93, 4'h9, 2'b01, 16'h5AA5, 2'b10, 2'b11});

    // 100 random back-to-back beats through the loopback
    cyc = 0; got = 0; sent = 0; last_acc = -1;
    for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
    drive_a($urandom, $urandom, rd, $urandom, $urandom, $urandom, $urandom);
    bus_a.user_downstream_vld = 1'b1;
    for (int c = 0; c < 400 && got < 100; c++) begin
      #1;
      acc = bus_a.user_downstream_vld && bus_a.user_downstream_ready;
      step();
      cyc++;
      if (acc) begin
        q_data.push_back(bus_a.dstrm_data);
        q_rest.push_back({bus_a.dstrm_state, bus_a.dstrm_protid, bus_a.dstrm_dvalid,
                          bus_a.dstrm_crc, bus_a.dstrm_crc_valid, bus_a.dstrm_valid});
        q_cyc.push_back(cyc);
        if (last_acc >= 0) check("rt_accept_spacing", cyc - last_acc, 2);
        last_acc = cyc;
        sent++;
        if (sent < 100) begin
          for (int w = 0; w < 16; w++) rd[w*32 +: 32] = $urandom;
          drive_a($urandom, $urandom, rd, $urandom, $urandom, $urandom, $urandom);
        end else begin
          bus_a.user_downstream_vld = 1'b0;
        end
      end
      if (bus_a.user_upstream_vld) begin
        if (q_data.size() == 0) begin
          check("rt_spurious_beat", 1'b1, 1'b0);
        end else begin
          check("rt_data", bus_a.ustrm_data, q_data.pop_front());
          check("rt_rest", rest_a(), q_rest.pop_front());
          check("rt_latency", cyc - q_cyc.pop_front(), 2);
        end
        got++;
      end
    end
    check("rt_beat_count", got, 100);

    // RX alignment: marker-1, marker-1, marker-0
    loop_a = 1'b0;
    w1 = {1'b1, mk_a(4'h7, 2'h3, d5, 1'b1, 8'h11, 1'b1, 1'b1)};
    w2 = {1'b1, mk_a(4'hB, 2'h0, da, 1'b0, 8'h22, 1'b1, 1'b0)};
    w3 = {1'b0, mk_a(4'hC, 2'h1, d1, 1'b1, 8'h33, 1'b0, 1'b1)};
    man_vld = 1'b1; man_data = w1;
    step();
    check("al_w1_err", bus_a.rx_align_err, 1'b0);
    man_data = w2;
    step();
    check("al_w2_err", bus_a.rx_align_err, 1'b1);
    check("al_w2_upvld", bus_a.user_upstream_vld, 1'b0);
    man_data = w3;
    step();
    check("al_w3_err", bus_a.rx_align_err, 1'b0);
    check("al_w3_upvld", bus_a.user_upstream_vld, 1'b1);
    check("al_data", bus_a.ustrm_data, {d1, da});
    check("al_rest", rest_a(), {8'hCB, 4'h4, 2'b10, 16'h3322, 2'b01, 2'b10});
    step();
    check("al_orphan_err", bus_a.rx_align_err, 1'b1);
    check("al_orphan_upvld", bus_a.user_upstream_vld, 1'b0);
    man_vld = 1'b0;
    step();
    check("al_idle_err", bus_a.rx_align_err, 1'b0);
    check("al_idle_hold", bus_a.ustrm_data, {d1, da});
    // Gap between chunks of one beat
    man_vld = 1'b1; man_data = w2;
    step();
    man_vld = 1'b0;
    step(); step();
    man_vld = 1'b1; man_data = w3;
    step();
    man_vld = 1'b0;
    check("gap_upvld", bus_a.user_upstream_vld, 1'b1);
    check("gap_err", bus_a.rx_align_err, 1'b0);

    // Reset mid-transfer
    loop_a = 1'b1;
    drive_a(8'h21, 4'h6, {da, d5}, 2'b11, 16'hC33C, 2'b11, 2'b11);
    bus_a.user_downstream_vld = 1'b1;
    step();
    bus_a.user_downstream_vld = 1'b0;
    check("mr_c0_vld", bus_a.txfifo_downstream_vld, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mr_txvld", bus_a.txfifo_downstream_vld, 1'b0);
    check("mr_txdata", bus_a.txfifo_downstream_data, '0);
    check("mr_ready", bus_a.user_downstream_ready, 1'b0);
    check("mr_udata", bus_a.ustrm_data, '0);
    step(); step();
    rst_n = 1'b1;
    hits = 0;
    for (int i = 0; i < 5; i++) begin
      step();
      if (bus_a.txfifo_downstream_vld || bus_a.user_upstream_vld) hits++;
    end
    check("mr_no_stale", hits, 0);
    check("mr_ready_back", bus_a.user_downstream_ready, 1'b1);

    // 4-slice beats over a 2-slice link
    for (int i = 0; i < 3; i++) begin
      bst = 16'h4321 + 16'(i); bpr = 8'hE4 ^ 8'(i); bdt = 64'h0123_4567_89AB_CDEF + 64'(i) * 64'h1111;
      bdv = 4'b1010 ^ 4'(i); bcrc = 32'hA1B2C3D4 ^ 32'(i); bcv = 4'hF; bv = 4'b0101 | 4'(i);
      bus_b.dstrm_state = bst; bus_b.dstrm_protid = bpr; bus_b.dstrm_data = bdt;
      bus_b.dstrm_dvalid = bdv; bus_b.dstrm_crc = bcrc; bus_b.dstrm_crc_valid = bcv;
      bus_b.dstrm_valid = bv;
      bus_b.user_downstream_vld = 1'b1;
      #1 check("b4_ready", bus_b.user_downstream_ready, 1'b1);
      step();
      bus_b.user_downstream_vld = 1'b0;
      check("b4_c0_word", bus_b.txfifo_downstream_data,
            {1'b1, mk_b(bst[7:4], bpr[3:2], bdt[31:16], bdv[1], bcrc[15:8], bcv[1], bv[1]),
                   mk_b(bst[3:0], bpr[1:0], bdt[15:0],  bdv[0], bcrc[7:0],  bcv[0], bv[0])});
      step();
      check("b4_c1_word", bus_b.txfifo_downstream_data,
            {1'b0, mk_b(bst[15:12], bpr[7:6], bdt[63:48], bdv[3], bcrc[31:24], bcv[3], bv[3]),
                   mk_b(bst[11:8],  bpr[5:4], bdt[47:32], bdv[2], bcrc[23:16], bcv[2], bv[2])});
      done = 1'b0;
      for (int c = 0; c < 6 && !done; c++) begin
        step();
        if (bus_b.user_upstream_vld) done = 1'b1;
      end
      check("b4_up_seen", done, 1'b1);
      check("b4_beat", {bus_b.ustrm_state, bus_b.ustrm_protid, bus_b.ustrm_data, bus_b.ustrm_dvalid,
                        bus_b.ustrm_crc, bus_b.ustrm_crc_valid, bus_b.ustrm_valid},
                       {bst, bpr, bdt, bdv, bcrc, bcv, bv});
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
`default_nettype wire

// File: doc/lpif_txrx_asym_gearbox.md
Name: lpif_txrx_asym_gearbox

Overview:
Parametrised successor to the fixed x8 half-rate LPIF slice mapper. It serialises a wide LPIF user beat of USER_SLICES slices into LINK_SLICES-wide link words over RATIO cycles, and deserialises the reverse direction. A first-chunk marker bit keeps the receiver aligned, and ready/valid handshakes hold the TX beat while the link is stalled. It sits between the LPIF adapter and the logic-link TX/RX FIFOs.

Parameters:
USER_SLICES, 2, slices per user beat
LINK_SLICES, 1, slices per link word; USER_SLICES must be an integer multiple (RATIO = USER_SLICES/LINK_SLICES)
DATA_W, 256, data bits per slice
CRC_W, 8, crc bits per slice
(derived) SW = DATA_W+CRC_W+9 bits per slice; LW = LINK_SLICES*SW+1 bits per link word

Ports:
clk_wr  in  1  single clock
rst_wr_n  in  1  asynchronous active-low reset
dstrm_state  in  4*USER_SLICES  per-slice state
dstrm_protid  in  2*USER_SLICES  per-slice protocol id
dstrm_data  in  DATA_W*USER_SLICES  data
dstrm_dvalid/dstrm_crc_valid/dstrm_valid  in  USER_SLICES each  per-slice qualifiers
dstrm_crc  in  CRC_W*USER_SLICES  crc
user_downstream_vld  in  1  TX beat offered
user_downstream_ready  out  1  TX beat accepted when vld&ready
txfifo_downstream_data  out  LW  link word; bit LW-1 = first-chunk marker
txfifo_downstream_vld  out  1  link word valid
txfifo_downstream_ready  in  1  link accepts word
rxfifo_upstream_data  in  LW  received link word
rxfifo_upstream_vld  in  1  received word valid (no backpressure)
ustrm_state/protid/data/dvalid/crc/crc_valid/valid  out  same widths as dstrm_*  assembled beat
user_upstream_vld  out  1  one-cycle pulse per assembled beat
rx_align_err  out  1  one-cycle pulse on marker violation

Behaviour:
- Reset: all outputs 0 (user_downstream_ready = 0 during reset, 1 on the first cycle after). Internal TX/RX counters = 0. Partial beats are discarded.
- Slice layout (LSB first): state[0+:4], protid[4+:2], data[6+:DATA_W], dvalid, crc[+:CRC_W], crc_valid, valid. Slice i takes field bits [i*w +: w] of each dstrm_* vector.
- Chunk k (k = 0..RATIO-1) carries user slices [k*LINK_SLICES +: LINK_SLICES], slice 0 at the LSB. Marker = 1 only for k = 0.
TX:
- States IDLE and SEND, with chunk counter tx_k.
- IDLE: ready = 1. On vld&ready, register the beat and emit chunk 0 on the next cycle with txfifo_downstream_vld = 1; go to SEND.
- SEND: a word is held stable until txfifo_downstream_ready = 1, then tx_k increments.
- ready = 1 in SEND only when tx_k = RATIO-1 and txfifo_downstream_ready = 1. This allows back-to-back beats: the next beat's chunk 0 follows with no bubble.
- If no new beat arrives, return to IDLE with txfifo_downstream_vld = 0.
- RATIO = 1: a one-register pipeline, marker always 1.
- Throughput: 1 beat per RATIO cycles when the link is never stalled.
RX:
- rx_k counter plus a partial-beat register.
- On rxfifo_upstream_vld:
  - marker = 1: store the slices as chunk 0 and set rx_k = 1. If rx_k != 0, the previous partial is dropped and rx_align_err pulses.
  - marker = 0 with rx_k = 0: word dropped, rx_align_err pulses.
  - Otherwise: store at rx_k and increment.
- When chunk RATIO-1 is stored, the ustrm_* outputs update and user_upstream_vld pulses on the next cycle. ustrm_* hold their value until the next beat completes.
- Latency: last chunk in to user_upstream_vld = 1 cycle.
- An invalid rxfifo_upstream_vld cycle leaves state unchanged; gaps between chunks are allowed.

Decomposition:
- lpif_gearbox_pkg: field width constants (STATE_W = 4, PROTID_W = 2), SW/LW computation functions, and a packed slice struct typedef.
- One sub-module, lpif_slice_pack: combinational pack/unpack of one slice. It is instantiated USER_SLICES times in each direction.
- TX and RX stay in the top module as two independent always_ff blocks.

Test Plan:
- Defaults. Beat with state = 8'h21, protid = 4'h6, data = {256'hA.., 256'h5..}, all qualifiers = 2'b11, txfifo ready held 1 -> chunk 0 (marker 1, state 4'h1, data 256'h5..) at t+1, chunk 1 (marker 0, state 4'h2) at t+2, ready high at t+2.
- Stall txfifo_downstream_ready = 0 for 3 cycles during chunk 1 -> word stable for 3 cycles, user_downstream_ready = 0, no data loss.
- Loop TX to RX, 100 random back-to-back beats -> ustrm_* equal to dstrm_*, user_upstream_vld every 2nd cycle, 2-cycle extra latency.
- RX gets marker-1, marker-1, marker-0 -> one rx_align_err pulse; beat assembled from the 2nd and 3rd words.
- rst_wr_n asserted after chunk 0 mid-transfer -> outputs 0 immediately; no stale chunk 1 after release.
- USER_SLICES = 4, LINK_SLICES = 2 -> 2 chunks of 2 slices; round trip exact.
